// File: rtl/tree_endpoint_injector_if.sv
// Endpoint <-> injector bundle for one tree NoC injection port.
//   req_*    : packet request (dest endpoint, VC, payload length)
//   data_*   : payload word stream
//   flit_*   : registered flit write strobe towards the leaf router
//   credit_in: per-VC credit return pulses from the leaf router
//   credit_err, pkt_sent : status
// master = endpoint/router side, slave = injector.
interface tree_endpoint_injector_if #(
   parameter int DW = 4,   // destination index width
   parameter int VW = 1,   // VC index width
   parameter int V  = 2,   // number of VCs
   parameter int FW = 32   // flit width
);
   logic          req_valid;
   logic          req_ready;
   logic [DW-1:0] req_dest;
   logic [VW-1:0] req_vc;
   logic [7:0]    req_len;
   logic          data_valid;
   logic          data_ready;
   logic [FW-1:0] data_in;
   logic          flit_valid;
   logic          flit_hdr;
   logic          flit_tail;
   logic [V-1:0]  flit_vc;
   logic [FW-1:0] flit_data;
   logic [V-1:0]  credit_in;
   logic          credit_err;
   logic [15:0]   pkt_sent;

   modport master (
      output req_valid, req_dest, req_vc, req_len, data_valid, data_in, credit_in,
      input  req_ready, data_ready, flit_valid, flit_hdr, flit_tail, flit_vc, flit_data,
             credit_err, pkt_sent
   );

   modport slave (
      input  req_valid, req_dest, req_vc, req_len, data_valid, data_in, credit_in,
      output req_ready, data_ready, flit_valid, flit_hdr, flit_tail, flit_vc, flit_data,
             credit_err, pkt_sent
   );
endinterface

// File: rtl/tree_endpoint_injector.sv
// Endpoint-side packet injector for the tree NoC.
// Takes a packet request plus payload stream and emits header/body/tail flits
// under per-VC credit flow control towards the leaf router.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : tree_endpoint_injector_if.slave (request, payload, flit, credit, status)

// Per-VC credit counter. Starts full (B); take = flit issued on this VC,
// give = credit returned. Simultaneous take/give leaves the count unchanged.
// A give while already full (and not taking) is discarded and flagged.
module tree_endpoint_injector_credit #(
   parameter int B  = 4,
   parameter int CW = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic take,
   input  logic give,
   output logic ok,
   output logic err
);
   localparam logic [CW-1:0] FULL = CW'(B);

   logic [CW-1:0] cnt_q;

   assign ok  = (cnt_q != '0);
   assign err = give && !take && (cnt_q == FULL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= FULL;
      end else begin
         unique case ({take, give})
            2'b10:   cnt_q <= cnt_q - 1'b1;
            2'b01:   if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module tree_endpoint_injector #(
   parameter int K       = 3,
   parameter int L       = 2,
   parameter int V       = 2,
   parameter int B       = 4,
   parameter int Fw      = 32,
   parameter int SRC_ID  = 0,
   parameter int MAX_LEN = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   tree_endpoint_injector_if.slave bus
);
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int VW = (V > 1) ? $clog2(V) : 1;
   localparam int CW = $clog2(B + 1);
   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;

   state_t            state_q, state_d;
   logic [VW-1:0]     vc_q;
   logic [7:0]        len_q;
   logic [7:0]        cnt_q;      // payload words already issued
   logic [L*KW-1:0]   code_q;
   logic [L*KW-1:0]   dest_code_c;
   logic [Fw-1:0]     hdr_word;

   logic              req_ready_c, data_ready_c;
   logic              issue, is_hdr, is_tail;
   logic [Fw-1:0]     flit_d;
   logic [V-1:0]      issue_vec;
   logic [V-1:0]      cr_ok, cr_err;
   logic              cur_ok;

   logic              flit_valid_q, flit_hdr_q, flit_tail_q;
   logic [V-1:0]      flit_vc_q;
   logic [Fw-1:0]     flit_data_q;
   logic              credit_err_q;
   logic [15:0]       pkt_sent_q;

   // Base-K digits of the destination; digit 0 is the leaf port.
   always_comb begin
      int unsigned rem;
      rem = 32'(bus.req_dest);
      dest_code_c = '0;
      for (int i = 0; i < L; i++) begin
         dest_code_c[i*KW +: KW] = KW'(rem % K);
         rem = rem / K;
      end
   end

   always_comb begin
      hdr_word              = '0;
      hdr_word[7:0]         = len_q;
      hdr_word[15:8]        = 8'(SRC_ID);
      hdr_word[16 +: L*KW]  = code_q;
   end

   assign cur_ok    = cr_ok[vc_q];
   assign issue_vec = issue ? (V'(1) << vc_q) : '0;

   for (genvar v = 0; v < V; v++) begin : g_cr
      tree_endpoint_injector_credit #(.B(B), .CW(CW)) u_cr (
         .clk  (clk),
         .reset(reset),
         .take (issue_vec[v]),
         .give (bus.credit_in[v]),
         .ok   (cr_ok[v]),
         .err  (cr_err[v])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      req_ready_c  = 1'b0;
      data_ready_c = 1'b0;
      issue        = 1'b0;
      is_hdr       = 1'b0;
      is_tail      = 1'b0;
      flit_d       = '0;
      unique case (state_q)
         S_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) state_d = S_HDR;
         end
         S_HDR: begin
            if (cur_ok) begin
               issue   = 1'b1;
               is_hdr  = 1'b1;
               is_tail = (len_q == 8'd0);
               flit_d  = hdr_word;
               state_d = (len_q == 8'd0) ? S_IDLE : S_BODY;
            end
         end
         S_BODY: begin
            data_ready_c = cur_ok;
            if (cur_ok && bus.data_valid) begin
               issue   = 1'b1;
               flit_d  = bus.data_in;
               is_tail = (cnt_q == len_q - 8'd1);
               if (is_tail) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vc_q         <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         code_q       <= '0;
         flit_valid_q <= 1'b0;
         flit_hdr_q   <= 1'b0;
         flit_tail_q  <= 1'b0;
         flit_vc_q    <= '0;
         flit_data_q  <= '0;
         credit_err_q <= 1'b0;
         pkt_sent_q   <= '0;
      end else begin
         if (state_q == S_IDLE && bus.req_valid) begin
            vc_q   <= bus.req_vc;
            len_q  <= (bus.req_len > LEN_MAX) ? LEN_MAX : bus.req_len;
            code_q <= dest_code_c;
            cnt_q  <= '0;
         end else if (issue && !is_hdr) begin
            cnt_q  <= cnt_q + 8'd1;
         end
         // flit_* are zero whenever no flit was issued the cycle before
         flit_valid_q <= issue;
         flit_hdr_q   <= is_hdr;
         flit_tail_q  <= is_tail;
         flit_vc_q    <= issue_vec;
         flit_data_q  <= flit_d;
         if (|cr_err)         credit_err_q <= 1'b1;
         if (issue && is_tail) pkt_sent_q  <= pkt_sent_q + 16'd1;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.data_ready = data_ready_c;
   assign bus.flit_valid = flit_valid_q;
   assign bus.flit_hdr   = flit_hdr_q;
   assign bus.flit_tail  = flit_tail_q;
   assign bus.flit_vc    = flit_vc_q;
   assign bus.flit_data  = flit_data_q;
   assign bus.credit_err = credit_err_q;
   assign bus.pkt_sent   = pkt_sent_q;
endmodule
